// File: rtl/fp_normalize128_arbiter.sv
// Round-robin arbiter that time-shares one fp128 normalizer between NREQ
// arithmetic units, with an operand register (S1) and a result register (S2).

package fp128Pkg;
   localparam int MSB  = 127;               // packed fp128 result, bits MSB..0
   localparam int EMSB = 14;                // exponent is EMSB+1 bits
   localparam int FMSB = 111;               // stored fraction is FMSB+1 bits
   localparam int FX   = 2*(FMSB+2) - 1;    // expanded mantissa is FX+1 bits
   localparam int EX   = FX + EMSB + 2;     // expanded operand is EX+1 bits
endpackage

// Expanded operand {sign, exponent, mantissa[FX:0]}; the mantissa binary point
// sits below bit FX-2, so a leading one at FX-2 leaves the exponent unchanged.
// Output is {sign, exponent, fraction, guard, round, sticky}.
module fpNormalize128Combo
   import fp128Pkg::*;
(
   input  logic           ce,
   input  logic [EX:0]    i,
   input  logic           under_i,
   output logic [MSB+3:0] o,
   output logic           under_o,
   output logic           inexact_o
);
   logic                   sgn;
   logic [EMSB:0]          exp_in;
   logic [FX:0]            man;
   logic [7:0]             lz;
   logic [FX+2:0]          man_sh;
   logic signed [EMSB+2:0] exp_adj;
   logic [FMSB:0]          frac;
   logic                   g_bit, r_bit, s_bit;

   assign sgn    = i[EX];
   assign exp_in = i[EX-1 -: EMSB+1];
   assign man    = i[FX:0];

   always_comb begin
      lz = 8'd0;
      for (int b = 0; b <= FX; b++) begin
         if (man[b]) lz = 8'(FX - b);
      end
   end

   // Two zero bits appended so a right-normalize by 1 or 2 keeps its bits for GRS.
   assign man_sh  = {man, 2'b00} << lz;
   assign exp_adj = $signed({2'b00, exp_in}) + 17'sd2 - $signed({9'd0, lz});
   assign frac    = man_sh[FX+1 -: FMSB+1];
   assign g_bit   = man_sh[FX-FMSB];
   assign r_bit   = man_sh[FX-FMSB-1];
   assign s_bit   = |man_sh[FX-FMSB-2:0];

   always_comb begin
      o         = '0;
      under_o   = 1'b0;
      inexact_o = 1'b0;
      if (ce) begin
         under_o = under_i;
         if (!man_sh[FX+2]) begin
            o = {sgn, {(MSB+3){1'b0}}};
         end else if (exp_adj >= 17'sd32767) begin
            o         = {sgn, {(EMSB+1){1'b1}}, {(FMSB+4){1'b0}}};
            inexact_o = 1'b1;
         end else if (exp_adj <= 17'sd0) begin
            o         = {sgn, {(EMSB+1){1'b0}}, frac, g_bit, r_bit, s_bit};
            under_o   = 1'b1;
            inexact_o = g_bit | r_bit | s_bit;
         end else begin
            o         = {sgn, exp_adj[EMSB:0], frac, g_bit, r_bit, s_bit};
            inexact_o = g_bit | r_bit | s_bit;
         end
      end
   end
endmodule

module fp_normalize128_arbiter
   import fp128Pkg::*;
#(
   parameter int NREQ = 4,
   parameter int TAGW = 4
)(
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       ce,
   input  logic [NREQ-1:0]            req_valid,
   output logic [NREQ-1:0]            req_ready,
   input  logic [NREQ*(EX+1)-1:0]     req_i,
   input  logic [NREQ-1:0]            req_under,
   input  logic [NREQ*TAGW-1:0]       req_tag,
   output logic                       res_valid,
   input  logic                       res_ready,
   output logic [MSB+3:0]             res_o,
   output logic                       res_under,
   output logic                       res_inexact,
   output logic [$clog2(NREQ)-1:0]    res_src,
   output logic [TAGW-1:0]            res_tag
);
   localparam int SW = $clog2(NREQ);
   localparam int OW = EX + 1;

   logic [OW-1:0]   req_op [NREQ];
   logic [TAGW-1:0] req_tg [NREQ];

   logic            s1_valid_reg;
   logic [OW-1:0]   s1_op_reg;
   logic            s1_under_reg;
   logic [TAGW-1:0] s1_tag_reg;
   logic [SW-1:0]   s1_src_reg;
   logic [SW-1:0]   rr_ptr_reg;

   logic            s2_adv, s1_free, win_found, grant_en;
   logic [SW-1:0]   win_idx, cand;
   logic [MSB+3:0]  norm_o;
   logic            norm_under, norm_inexact;

   generate
      for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
         assign req_op[gi]    = req_i[gi*OW +: OW];
         assign req_tg[gi]    = req_tag[gi*TAGW +: TAGW];
         assign req_ready[gi] = grant_en && (win_idx == SW'(gi));
      end
   endgenerate

   assign s2_adv  = !res_valid || res_ready;
   assign s1_free = !s1_valid_reg || s2_adv;

   // Walk from the highest offset down so the closest requester to rr_ptr wins.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int off = NREQ-1; off >= 0; off--) begin
         cand = SW'((int'(rr_ptr_reg) + off) % NREQ);
         if (req_valid[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   assign grant_en = win_found && s1_free && ce && !rst;

   fpNormalize128Combo u_norm (
      .ce        (1'b1),
      .i         (s1_op_reg),
      .under_i   (s1_under_reg),
      .o         (norm_o),
      .under_o   (norm_under),
      .inexact_o (norm_inexact)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_reg <= 1'b0;
         s1_op_reg    <= '0;
         s1_under_reg <= 1'b0;
         s1_tag_reg   <= '0;
         s1_src_reg   <= '0;
         rr_ptr_reg   <= '0;
         res_valid    <= 1'b0;
         res_o        <= '0;
         res_under    <= 1'b0;
         res_inexact  <= 1'b0;
         res_src      <= '0;
         res_tag      <= '0;
      end else if (ce) begin
         if (s2_adv) begin
            res_valid <= s1_valid_reg;
            if (s1_valid_reg) begin
               res_o       <= norm_o;
               res_under   <= norm_under;
               res_inexact <= norm_inexact;
               res_src     <= s1_src_reg;
               res_tag     <= s1_tag_reg;
            end
         end
         if (grant_en) begin
            s1_valid_reg <= 1'b1;
            s1_op_reg    <= req_op[win_idx];
            s1_under_reg <= req_under[win_idx];
            s1_tag_reg   <= req_tg[win_idx];
            s1_src_reg   <= win_idx;
            rr_ptr_reg   <= (win_idx == SW'(NREQ-1)) ? '0 : win_idx + 1'b1;
         end else if (s2_adv) begin
            s1_valid_reg <= 1'b0;
         end
      end
   end
endmodule
